rt_frame_scheduler: RTL and testbench

RT_FRAME_SCHEDULER -- requirements
Module: rt_frame_scheduler

---
 rtl/rt_frame_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_rt_frame_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_frame_scheduler.sv
// rt_frame_scheduler
//   Walks a frame in raster order. For each pixel it launches the ray-trace
//   core, waits for a fresh result (or times out), writes the pixel into the
//   framebuffer under back-pressure, then advances to the next pixel.
//
// Ports
//   CLK          system clock, all state on the rising edge
//   RESET_N      synchronous active-low reset
//   START        frame request, honoured only in IDLE
//   ABORT        drop the current frame and return to IDLE
//   CORE_ENABLE  one-cycle launch pulse to the core
//   CORE_X/Y     pixel coordinate presented to the core
//   CORE_READY   core result valid (level), accepted only on its rising edge
//   CORE_PIXEL   core result
//   FB_WE        framebuffer write strobe, held while FB_STALL is high
//   FB_ADDR      linear framebuffer address (Y*H_RES+X), kept incrementally
//   FB_DATA      pixel being written
//   FB_STALL     framebuffer back-pressure
//   BUSY         high outside IDLE
//   FRAME_DONE   one-cycle pulse after the last pixel is written
//   TIMEOUT_ERR  sticky timeout flag, cleared by START or reset
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for START
// ISSUE   | pulse CORE_ENABLE for the current pixel, clear wait counter
// WAIT    | wait for a READY rising edge or the wait-counter timeout
// WRITE   | drive FB_WE until the framebuffer accepts (FB_STALL low)
// ADVANCE | step X/Y/FB_ADDR, or finish after the last pixel
// DONE    | pulse FRAME_DONE, return to IDLE
module rt_frame_scheduler #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned TIMEOUT   = 4095,
  parameter logic [3:0]  ERR_PIXEL = 4'hF
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        ABORT,
  output logic        CORE_ENABLE,
  output logic [9:0]  CORE_X,
  output logic [8:0]  CORE_Y,
  input  logic        CORE_READY,
  input  logic [3:0]  CORE_PIXEL,
  output logic        FB_WE,
  output logic [18:0] FB_ADDR,
  output logic [3:0]  FB_DATA,
  input  logic        FB_STALL,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        TIMEOUT_ERR
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic [18:0]        addr_q, addr_d;
  logic [3:0]         data_q, data_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               err_q, err_d;
  logic               ready_q;

  logic               core_enable_c;
  logic               fb_we_c;
  logic               frame_done_c;
  logic               ready_edge;
  logic               last_col;
  logic               last_row;

  // A level-high READY left over from an earlier pixel must not be taken as
  // a new result, so only a low-to-high transition counts.
  assign ready_edge = CORE_READY & ~ready_q;
  assign last_col   = (x_q == 10'(H_RES - 1));
  assign last_row   = (y_q == 9'(V_RES - 1));

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wait_cnt_d    = wait_cnt_q;
    err_d         = err_q;
    core_enable_c = 1'b0;
    fb_we_c       = 1'b0;
    frame_done_c  = 1'b0;

    if (ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_ISSUE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            err_d   = 1'b0;
          end
        end
        S_ISSUE: begin
          core_enable_c = 1'b1;
          wait_cnt_d    = '0;
          state_d       = S_WAIT;
        end
        S_WAIT: begin
          if (ready_edge) begin
            data_d  = CORE_PIXEL;
            state_d = S_WRITE;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
            data_d  = ERR_PIXEL;
            err_d   = 1'b1;
            state_d = S_WRITE;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          fb_we_c = 1'b1;
          if (!FB_STALL) begin
            state_d = S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          // The last pixel keeps its coordinates so X, Y and FB_ADDR never
          // step past the frame.
          if (last_col && last_row) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            addr_d  = addr_q + 1'b1;
            if (last_col) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          frame_done_c = 1'b1;
          state_d      = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      ready_q    <= CORE_READY;
    end
  end

  // Strobes are masked while reset is asserted so a frame interrupted by
  // reset never produces a partial write or launch in that cycle.
  assign CORE_ENABLE = core_enable_c & RESET_N;
  assign FB_WE       = fb_we_c & RESET_N;
  assign FRAME_DONE  = frame_done_c & RESET_N;
  assign CORE_X      = x_q;
  assign CORE_Y      = y_q;
  assign FB_ADDR     = addr_q;
  assign FB_DATA     = data_q;
  assign BUSY        = (state_q != S_IDLE);
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_rt_frame_scheduler.sv
// Bench for rt_frame_scheduler on a 4x2 frame with TIMEOUT=10.
module tb_rt_frame_scheduler;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int TMO  = 10;

  logic        clk = 1'b0;
  logic        reset_n, start, abort;
  logic        core_enable, core_ready, fb_we, fb_stall;
  logic [9:0]  core_x;
  logic [8:0]  core_y;
  logic [3:0]  core_pixel, fb_data;
  logic [18:0] fb_addr;
  logic        busy, frame_done, timeout_err;

  rt_frame_scheduler #(
    .H_RES(H), .V_RES(V), .TIMEOUT(TMO), .ERR_PIXEL(4'hF)
  ) dut (
    .CLK(clk), .RESET_N(reset_n), .START(start), .ABORT(abort),
    .CORE_ENABLE(core_enable), .CORE_X(core_x), .CORE_Y(core_y),
    .CORE_READY(core_ready), .CORE_PIXEL(core_pixel),
    .FB_WE(fb_we), .FB_ADDR(fb_addr), .FB_DATA(fb_data), .FB_STALL(fb_stall),
    .BUSY(busy), .FRAME_DONE(frame_done), .TIMEOUT_ERR(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t wr_q[$];
  int  n_done = 0;
  int  n_en = 0;

  // environment configuration
  bit         core_auto = 1'b1;
  int         cfg_delay = 3;
  int         cfg_stall = 0;
  bit         rand_stall = 1'b0;
  logic [7:0] noresp = '0;
  int         cur_stall = 0;

  typedef struct {
    string      name;
    int         delay;
    int         stall;
    logic [7:0] mask;
    logic [31:0] exp_data;
    logic       exp_err;
  } vec_t;
  vec_t vec[5];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " core_enable"}, core_enable, 0);
    check({tag, " fb_we"}, fb_we, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " timeout_err"}, timeout_err, 0);
    check({tag, " core_x"}, core_x, 0);
    check({tag, " core_y"}, core_y, 0);
    check({tag, " fb_addr"}, fb_addr, 0);
    check({tag, " fb_data"}, fb_data, 0);
  endtask

  // Reference frame: raster order, pixel value x+y unless the core is silent
  // for that pixel, in which case the error pixel is written.
  function automatic logic [31:0] model_frame(input logic [7:0] mask);
    logic [31:0] r;
    r = '0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        r[(y*H + x)*4 +: 4] = mask[y*H + x] ? 4'hF : 4'(x + y);
    return r;
  endfunction

  // Core model: READY pulses for one cycle, cfg_delay cycles after ENABLE.
  initial begin
    int cnt, px, idx;
    bit pending, raised;
    cnt = 0; px = 0; pending = 0; raised = 0;
    core_ready = 1'b0;
    core_pixel = '0;
    forever begin
      @(negedge clk);
      if (core_auto) begin
        if (raised) begin core_ready = 1'b0; raised = 0; end
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            core_ready = 1'b1; core_pixel = 4'(px); raised = 1; pending = 0;
          end
        end
        if (core_enable) begin
          idx = int'(core_y) * H + int'(core_x);
          pending = 0;
          if (idx < NPIX && !noresp[idx]) begin
            pending = 1; cnt = cfg_delay; px = int'(core_x) + int'(core_y);
          end
        end
      end else begin
        pending = 0; raised = 0;
      end
    end
  end

  // Framebuffer back-pressure model.
  initial begin
    int left;
    bit act;
    left = 0; act = 0;
    fb_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (fb_we) begin
        if (!act) begin
          act = 1;
          left = rand_stall ? int'($urandom_range(0, 3)) : cfg_stall;
          cur_stall = left;
        end
        fb_stall = (left > 0);
        if (left > 0) left--;
      end else begin
        act = 0; fb_stall = 1'b0;
      end
    end
  end

  // Monitor: records completed writes and checks per-pixel protocol.
  initial begin
    bit in_wr, prev_en, have_wr;
    int we_cyc, en_cyc, last_wr_cyc, ex, ey, exp_lat;
    logic [18:0] a0;
    logic [3:0]  d0;
    in_wr = 0; prev_en = 0; have_wr = 0;
    we_cyc = 0; en_cyc = 0; last_wr_cyc = 0; ex = 0; ey = 0;
    a0 = '0; d0 = '0;
    forever begin
      @(negedge clk); #1;
      if (!busy) have_wr = 0;
      if (core_enable) begin
        n_en++;
        check("enable_not_back_to_back", prev_en, 0);
        check("enable_x", core_x, wr_q.size() % H);
        check("enable_y", core_y, wr_q.size() / H);
        if (have_wr) check("issue_two_after_write", cyc - last_wr_cyc, 2);
        en_cyc = cyc; ex = int'(core_x); ey = int'(core_y);
      end
      prev_en = core_enable;
      if (fb_we) begin
        if (!in_wr) begin
          in_wr = 1; we_cyc = 0; a0 = fb_addr; d0 = fb_data;
          check("write_addr_matches_pixel", fb_addr, ey*H + ex);
        end else begin
          check("stalled_addr_stable", fb_addr, a0);
          check("stalled_data_stable", fb_data, d0);
        end
        we_cyc++;
        if (!fb_stall) begin
          wr_q.push_back('{int'(fb_addr), int'(fb_data)});
          check("we_cycles_per_write", we_cyc, cur_stall + 1);
          if (core_auto && (ey*H + ex) < NPIX) begin
            exp_lat = (noresp[ey*H + ex] ? TMO + 2 : cfg_delay + 1) + cur_stall;
            check("write_latency_from_enable", cyc - en_cyc, exp_lat);
          end
          last_wr_cyc = cyc; have_wr = 1; in_wr = 0;
        end
      end else begin
        in_wr = 0;
      end
      if (frame_done) n_done++;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] exp_data, input logic exp_err, input string tag);
    int k;
    wr_q.delete(); n_done = 0;
    pulse_start();
    #1 check({tag, " err_cleared_at_start"}, timeout_err, 0);
    check({tag, " busy_after_start"}, busy, 1);
    for (k = 0; k < 3000 && n_done == 0; k++) @(negedge clk);
    check({tag, " frame_done_seen"}, n_done, 1);
    #1 check({tag, " busy_low_after_done"}, busy, 0);
    repeat (3) @(negedge clk);
    #1 check({tag, " one_frame_done"}, n_done, 1);
    check({tag, " write_count"}, wr_q.size(), NPIX);
    for (int i = 0; i < NPIX && i < wr_q.size(); i++) begin
      check({tag, " addr"}, wr_q[i].addr, i);
      check({tag, " data"}, wr_q[i].data, exp_data[i*4 +: 4]);
    end
    check({tag, " timeout_err"}, timeout_err, exp_err);
  endtask

  task automatic wait_pixel(input int x, input int y, input string tag);
    int k;
    for (k = 0; k < 400 && !(core_enable && core_x == 10'(x) && core_y == 9'(y)); k++)
      @(negedge clk);
    check({tag, " reached_pixel"}, k < 400, 1);
  endtask

  initial begin
    int k;
    logic [7:0]  m;
    logic [31:0] d32;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;

    vec[0] = '{"basic_d3",      3, 0, 8'h00, 32'h4321_3210, 1'b0};
    vec[1] = '{"min_latency",   1, 0, 8'h00, 32'h4321_3210, 1'b0};
    vec[2] = '{"timeout_px1",   3, 0, 8'h02, 32'h4321_32F0, 1'b1};
    vec[3] = '{"stall5",        2, 5, 8'h00, 32'h4321_3210, 1'b0};
    vec[4] = '{"timeout_ends",  6, 1, 8'h81, 32'hF321_321F, 1'b1};

    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("idle_without_start", busy, 0);

    foreach (vec[i]) begin
      core_auto = 1; rand_stall = 0;
      cfg_delay = vec[i].delay; cfg_stall = vec[i].stall; noresp = vec[i].mask;
      run_frame(vec[i].exp_data, vec[i].exp_err, vec[i].name);
    end

    for (int r = 0; r < 6; r++) begin
      m = '0;
      for (int b = 0; b < NPIX; b++) if ($urandom_range(0, 7) == 0) m[b] = 1'b1;
      cfg_delay = int'($urandom_range(1, 6)); rand_stall = 1; noresp = m;
      d32 = model_frame(m);
      run_frame(d32, |m, "random");
    end
    rand_stall = 0; cfg_stall = 0; noresp = '0; cfg_delay = 3;

    // READY held high: one write per launch, a new result needs a new edge.
    core_auto = 0; core_ready = 1'b0; wr_q.delete(); n_en = 0;
    pulse_start();
    for (k = 0; k < 20 && !core_enable; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    core_ready = 1'b1; core_pixel = 4'd5;
    repeat (3) @(negedge clk);
    #1 check("hold first_write_count", wr_q.size(), 1);
    if (wr_q.size() > 0) check("hold first_write_data", wr_q[0].data, 5);
    for (k = 0; k < 20 && !core_enable; k++) @(negedge clk);
    repeat (8) @(negedge clk);
    #1 check("hold no_write_while_high", wr_q.size(), 1);
    core_ready = 1'b0;
    @(negedge clk) begin core_ready = 1'b1; core_pixel = 4'd6; end
    repeat (2) @(negedge clk);
    #1 check("hold second_write_count", wr_q.size(), 2);
    if (wr_q.size() > 1) begin
      check("hold second_write_data", wr_q[1].data, 6);
      check("hold second_write_addr", wr_q[1].addr, 1);
    end
    check("hold enables", n_en, 2);
    check("hold no_timeout", timeout_err, 0);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) begin abort = 1'b0; core_ready = 1'b0; core_auto = 1; end
    #1 check("hold abort_idle", busy, 0);

    // Abort at pixel (2,1) with a timeout earlier in the frame.
    noresp = 8'h01; wr_q.delete();
    pulse_start();
    wait_pixel(2, 1, "abort");
    @(negedge clk) abort = 1'b1;
    #1 check("abort no_we", fb_we, 0);
    check("abort no_done", frame_done, 0);
    @(negedge clk) abort = 1'b0;
    #1 check("abort busy_drops", busy, 0);
    check("abort err_sticky", timeout_err, 1);
    check("abort writes_before", wr_q.size(), 6);
    noresp = '0;
    run_frame(model_frame(8'h00), 1'b0, "after_abort");

    // Abort while a write is stalled: the strobe must drop in that cycle.
    cfg_stall = 5; wr_q.delete();
    pulse_start();
    for (k = 0; k < 50 && !fb_we; k++) @(negedge clk);
    @(negedge clk) abort = 1'b1;
    #1 check("abort_stalled no_we", fb_we, 0);
    @(negedge clk) abort = 1'b0;
    #1 check("abort_stalled busy", busy, 0);
    check("abort_stalled no_write", wr_q.size(), 0);
    cfg_stall = 0;

    // START mid-frame is ignored; reset mid-WAIT clears everything.
    wr_q.delete();
    pulse_start();
    wait_pixel(1, 0, "midstart");
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (k = 0; k < 50 && wr_q.size() < 2; k++) @(negedge clk);
    #1 check("midstart write_count", wr_q.size(), 2);
    if (wr_q.size() > 1) check("midstart addr_not_reset", wr_q[1].addr, 1);
    wait_pixel(2, 0, "reset");
    @(negedge clk) reset_n = 1'b0;
    #1 check("reset_cycle no_we", fb_we, 0);
    @(negedge clk) reset_n = 1'b1;
    #1 check_all_zero("midframe_reset");
    repeat (4) @(negedge clk);
    #1 check("reset needs_start", busy, 0);
    run_frame(model_frame(8'h00), 1'b0, "after_reset");

    // Reset while a write is stalled.
    cfg_stall = 5; wr_q.delete();
    pulse_start();
    for (k = 0; k < 50 && !fb_we; k++) @(negedge clk);
    @(negedge clk) reset_n = 1'b0;
    #1 check("reset_stalled no_we", fb_we, 0);
    @(negedge clk) reset_n = 1'b1;
    #1 check("reset_stalled busy", busy, 0);
    check("reset_stalled no_write", wr_q.size(), 0);
    cfg_stall = 0;

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
